// File: rtl/snapshot_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snapshot_capture_ctrl
// Brief    : Software-armed snapshot capture into a BRAM write port.
// Revision : 1.0 - initial release
// ============================================================================
module snapshot_capture_ctrl #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              trig_in,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic              bram_we,
    output logic [31:0]       status
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [ADDR_W:0] C_LAST = {1'b0, {ADDR_W{1'b1}}};

    logic [1:0]        r_state;
    logic [31:0]       r_ctrl_q;
    logic [ADDR_W:0]   r_count;
    logic              r_done;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [31:0]       r_status;

    logic w_arm_edge;
    logic w_trig_hit;
    logic w_capture;
    logic w_write;
    logic w_abort;
    logic w_busy;
    logic [31:0] w_status;
    logic w_unused_ctrl;

    assign w_arm_edge    = ctrl[0] & ~r_ctrl_q[0];
    assign w_abort       = ctrl[3];
    assign w_trig_hit    = ctrl[1] | trig_in;
    assign w_capture     = (r_state == S_CAPTURE) || ((r_state == S_ARMED) && w_trig_hit);
    assign w_write       = w_capture && (!ctrl[2] || din_valid);
    assign w_busy        = (r_state == S_ARMED) || (r_state == S_CAPTURE);
    assign w_unused_ctrl = ^{ctrl[31:4], r_ctrl_q[31:1]};

    always_comb begin
        w_status             = '0;
        w_status[31]         = r_done;
        w_status[30]         = w_busy;
        w_status[ADDR_W:0]   = r_count;
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state  <= S_IDLE;
            r_ctrl_q <= '0;
            r_count  <= '0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_status <= '0;
        end else begin
            r_ctrl_q <= ctrl;
            r_we     <= 1'b0;
            r_status <= w_status;
            // Abort dominates arm edges and triggers; the count is kept for software.
            if (w_abort) begin
                r_state <= S_IDLE;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (w_arm_edge) begin
                            r_state <= S_ARMED;
                            r_done  <= 1'b0;
                            r_count <= '0;
                        end
                    end
                    S_ARMED, S_CAPTURE: begin
                        if (w_capture) begin
                            r_state <= S_CAPTURE;
                        end
                        if (w_write) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_count[ADDR_W-1:0];
                            r_data  <= din;
                            r_count <= r_count + 1'b1;
                            if (r_count == C_LAST) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bram_we   = r_we;
    assign bram_addr = r_addr;
    assign bram_data = r_data;
    assign status    = r_status;

endmodule
`default_nettype wire

// File: tb/tb_snapshot_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snapshot_capture_ctrl
// Brief    : Directed and randomized bench for snapshot_capture_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snapshot_capture_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       ctrl;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              trig_in;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;
    logic [31:0]       status;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 finished
    int                phase     = 0;
    int                mcount    = 0;
    bit                mdone     = 0;
    bit                prev_arm  = 0;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [31:0]       exp_status;
    int                din_cnt   = 0;

    snapshot_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .user_clk (clk),
        .user_rst (rst),
        .ctrl     (ctrl),
        .din      (din),
        .din_valid(din_valid),
        .trig_in  (trig_in),
        .bram_addr(bram_addr),
        .bram_data(bram_data),
        .bram_we  (bram_we),
        .status   (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input logic [31:0] c, input logic [DATA_W-1:0] d,
                        input logic v, input logic t, input logic r);
        bit arm_edge;
        ctrl = c; din = d; din_valid = v; trig_in = t; rst = r;
        if (r) begin
            phase = 0; mcount = 0; mdone = 0; prev_arm = 0;
            exp_we = 0; exp_addr = '0; exp_data = '0; exp_status = '0;
        end else begin
            exp_status = 32'(mcount);
            exp_status[31] = mdone;
            exp_status[30] = (phase == 1 || phase == 2);
            arm_edge = c[0] && !prev_arm;
            prev_arm = c[0];
            exp_we = 0;
            if (c[3]) begin
                phase = 0; mdone = 0;
            end else if (phase == 0 || phase == 3) begin
                if (arm_edge) begin phase = 1; mdone = 0; mcount = 0; end
            end else if (phase == 2 || c[1] || t) begin
                phase = 2;
                if (!c[2] || v) begin
                    exp_we   = 1;
                    exp_addr = ADDR_W'(mcount % DEPTH);
                    exp_data = d;
                    mcount++;
                    if (mcount == DEPTH) begin phase = 3; mdone = 1; end
                end
            end
        end
        @(posedge clk);
        #1;
        check("bram_we", 64'(bram_we), 64'(exp_we));
        check("bram_addr", 64'(bram_addr), 64'(exp_addr));
        check("bram_data", 64'(bram_data), 64'(exp_data));
        check("status", 64'(status), 64'(exp_status));
    endtask

    task automatic run(input logic [31:0] c, input int n, input logic v_toggle);
        for (int i = 0; i < n; i++) begin
            din_cnt++;
            step(c, DATA_W'(din_cnt), v_toggle ? logic'(i % 2 == 0) : 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] rc;
        logic [DATA_W-1:0] trig_din;
        rc = '0;
        for (int i = 0; i < 3; i++) step(32'h0, '0, 1'b0, 1'b0, 1'b1);
        check("reset_status", 64'(status), 64'h0);
        check("reset_we", 64'(bram_we), 64'h0);

        // Immediate capture with a counter as data
        run(32'h2, 1, 1'b0);
        run(32'h3, 20, 1'b0);
        check("imm_status", 64'(status), 64'h80000010);

        // External trigger
        run(32'h0, 1, 1'b0);
        run(32'h1, 20, 1'b0);
        check("ext_busy", 64'(status[30]), 64'h1);
        check("ext_nowrite", 64'(mcount), 64'(status[ADDR_W:0]));
        din_cnt++;
        trig_din = DATA_W'(din_cnt);
        step(32'h1, trig_din, 1'b1, 1'b1, 1'b0);
        check("ext_first_data", 64'(bram_data), 64'(trig_din));
        check("ext_first_addr", 64'(bram_addr), 64'h0);
        run(32'h1, 20, 1'b0);
        check("ext_status", 64'(status), 64'h80000010);

        // Valid gating: 16 valid words over 32 cycles
        run(32'h0, 1, 1'b0);
        run(32'h7, 1, 1'b0);
        run(32'h7, 34, 1'b1);
        check("valid_status", 64'(status), 64'h80000010);

        // Abort at count 7, then re-arm
        run(32'h0, 1, 1'b0);
        run(32'h3, 1, 1'b0);
        for (int i = 0; i < 20 && mcount != 7; i++) run(32'h3, 1, 1'b0);
        run(32'hB, 1, 1'b0);
        check("abort_we", 64'(bram_we), 64'h0);
        run(32'hB, 1, 1'b0);
        check("abort_status", 64'(status), 64'h7);
        run(32'h0, 1, 1'b0);
        run(32'h3, 2, 1'b0);
        check("rearm_addr", 64'(bram_addr), 64'h0);

        // Arm edge during capture is ignored, then reset mid-capture
        run(32'h2, 1, 1'b0);
        run(32'h3, 3, 1'b0);
        run(32'h3, 3, 1'b0);
        step(32'h0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_status", 64'(status), 64'h0);
        check("rst_we", 64'(bram_we), 64'h0);
        run(32'h0, 3, 1'b0);
        check("rst_idle", 64'(status), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19, 0) == 0) rc[0] = ~rc[0];
            if ($urandom_range(29, 0) == 0) rc[1] = ~rc[1];
            if ($urandom_range(29, 0) == 0) rc[2] = ~rc[2];
            rc[3] = ($urandom_range(49, 0) == 0);
            rc[31:4] = 28'($urandom);
            step(rc, DATA_W'($urandom), 1'($urandom), ($urandom_range(7, 0) == 0),
                 ($urandom_range(299, 0) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
